// File: rtl/fifo_drain_master_if.sv
// FIFO read port plus memory write-bus signals for fifo_drain_master.
// master = drain engine side; slave = FIFO/interconnect side.
interface fifo_drain_master_if #(
  parameter int DW     = 32,
  parameter int ADDR_W = 32
);
  logic              data_valid;
  logic [DW-1:0]     mstr0_data;
  logic              fifo_threshold;
  logic              mstr0_ready;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_len;
  logic              bus_gnt;
  logic              bus_wvalid;
  logic [DW-1:0]     bus_wdata;
  logic              bus_wlast;
  logic              bus_wready;

  modport master (
    input  data_valid, mstr0_data, fifo_threshold, bus_gnt, bus_wready,
    output mstr0_ready, bus_req, bus_addr, bus_len, bus_wvalid, bus_wdata, bus_wlast
  );

  modport slave (
    output data_valid, mstr0_data, fifo_threshold, bus_gnt, bus_wready,
    input  mstr0_ready, bus_req, bus_addr, bus_len, bus_wvalid, bus_wdata, bus_wlast
  );
endinterface

// File: rtl/fifo_drain_master.sv
// Drains the FWFT pixel FIFO into memory as address/data bursts.
// Optional FIFO_DRAIN_PERF_EN adds the stall_cycles counter output.
module fifo_drain_master #(
  parameter int DW        = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       total_words,
  output logic              busy,
  output logic              done,
`ifdef FIFO_DRAIN_PERF_EN
  output logic [15:0]       stall_cycles,
`endif
  fifo_drain_master_if.master m
);

  typedef enum logic [2:0] {IDLE, WAIT, REQ, DATA, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       rem;
  logic [15:0]       rem_next;
  logic [3:0]        len;
  logic [3:0]        beat;
  logic              req;
  logic [4:0]        wait_blen;
  logic [4:0]        data_blen;
  logic              short_job;
  logic              trigger;
  logic              in_data;
  logic              fire;
  logic              last;

  always_comb begin
    short_job = rem < 16'(BURST_LEN);
    wait_blen = short_job ? rem[4:0] : 5'(BURST_LEN);
    data_blen = {1'b0, len} + 5'd1;
    rem_next  = rem - 16'(data_blen);
    trigger   = m.fifo_threshold | (short_job & m.data_valid);
    in_data   = (state == DATA);
    fire      = in_data & m.data_valid & m.bus_wready;
    last      = (beat == len);
  end

  assign m.mstr0_ready = in_data & m.bus_wready;
  assign m.bus_wvalid  = in_data & m.data_valid;
  assign m.bus_wdata   = in_data ? m.mstr0_data : '0;
  assign m.bus_wlast   = in_data & last;
  assign m.bus_req     = req;
  assign m.bus_addr    = req_addr;
  assign m.bus_len     = len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      req_addr <= '0;
      rem      <= '0;
      len      <= '0;
      beat     <= '0;
      req      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr  <= base_addr;
          rem   <= total_words;
          busy  <= 1'b1;
          state <= (total_words == 16'd0) ? DONE : WAIT;
        end
        WAIT: if (trigger) begin
          len      <= 4'(wait_blen - 5'd1);
          req_addr <= addr;
          req      <= 1'b1;
          state    <= REQ;
        end
        REQ: if (m.bus_gnt) begin
          req   <= 1'b0;
          beat  <= '0;
          state <= DATA;
        end
        DATA: if (fire) begin
          beat <= beat + 4'd1;
          if (last) begin
            rem  <= rem_next;
            addr <= addr + ADDR_W'(data_blen) * ADDR_W'(DW / 8);
            if (rem_next == 16'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        // Entered from DATA, done is already set; a zero-length job arrives
        // with done low and spends one extra DONE cycle raising it.
        DONE: if (!done) begin
          done <= 1'b1;
        end else begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_DRAIN_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (in_data && !fire && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_master.sv
// Directed bench for fifo_drain_master with a 16-deep FWFT FIFO model.
// Build with FIFO_DRAIN_PERF_EN to also check stall_cycles.
module tb_fifo_drain_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] total_words = '0;
  logic        busy;
  logic        done;
`ifdef FIFO_DRAIN_PERF_EN
  logic [15:0] stall_cycles;
`endif
  logic        gnt = 1'b0;
  logic        wready = 1'b0;
  logic        push_en = 1'b0;
  logic [31:0] push_data = '0;

  int checks = 0;
  int errors = 0;

  fifo_drain_master_if #(.DW(32), .ADDR_W(32)) link ();

  fifo_drain_master #(.DW(32), .ADDR_W(32), .BURST_LEN(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .total_words (total_words),
    .busy        (busy),
    .done        (done),
`ifdef FIFO_DRAIN_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .m           (link.master)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on mstr0_ready & data_valid, one optional push per cycle
  logic [31:0] mem [0:15];
  logic [3:0]  rd = '0;
  logic [3:0]  wr = '0;
  int          cnt = 0;

  assign link.data_valid     = (cnt != 0);
  assign link.mstr0_data     = mem[rd];
  assign link.fifo_threshold = (cnt >= 8);
  assign link.bus_gnt        = gnt;
  assign link.bus_wready     = wready;

  always @(posedge clk) begin
    int n;
    n = cnt;
    if (link.mstr0_ready && link.data_valid) begin
      rd <= rd + 4'd1;
      n--;
    end
    if (push_en) begin
      mem[wr] <= push_data;
      wr <= wr + 4'd1;
      n++;
    end
    cnt <= n;
  end

  int          nbeats = 0, nreq = 0, nreqcyc = 0, ndone = 0, pops = 0, gaps = 0, bad_pop = 0;
  logic [31:0] beat_data [0:127];
  logic        beat_last [0:127];
  logic [31:0] req_addr_log [0:31];
  logic [3:0]  req_len_log [0:31];

  always @(posedge clk) begin
    if (link.bus_wvalid && wready && nbeats < 128) begin
      beat_data[nbeats] = link.bus_wdata;
      beat_last[nbeats] = link.bus_wlast;
      nbeats++;
    end
    if (link.bus_req) nreqcyc++;
    if (link.bus_req && gnt && nreq < 32) begin
      req_addr_log[nreq] = link.bus_addr;
      req_len_log[nreq]  = link.bus_len;
      nreq++;
    end
    if (done) ndone++;
    if (link.mstr0_ready && link.data_valid) pops++;
    if (link.mstr0_ready && !link.bus_wvalid) gaps++;
    if (link.mstr0_ready && !wready) bad_pop++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_en   = 1'b1;
      push_data = first + 32'(i);
    end
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] total);
    @(negedge clk);
    start       = 1'b1;
    base_addr   = base;
    total_words = total;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},   32'(busy), 32'd0);
    check({tag, " done"},   32'(done), 32'd0);
    check({tag, " req"},    32'(link.bus_req), 32'd0);
    check({tag, " wvalid"}, 32'(link.bus_wvalid), 32'd0);
    check({tag, " wlast"},  32'(link.bus_wlast), 32'd0);
    check({tag, " ready"},  32'(link.mstr0_ready), 32'd0);
    check({tag, " addr"},   link.bus_addr, 32'd0);
    check({tag, " len"},    32'(link.bus_len), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, d0, p0, g0, q0, c0;
    logic [15:0] lmask;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    gnt = 1'b1;
    wready = 1'b1;

    // two full bursts, plus a start pulse while busy that must be ignored
    push_burst(32'h0, 16);
    b0 = nbeats; r0 = nreq; d0 = ndone; p0 = pops;
    do_start(32'h1000, 16'd16);
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 req_n1", 32'(link.bus_req), 32'd0);
    @(negedge clk);
    check("t1 req_n2", 32'(link.bus_req), 32'd1);
    check("t1 addr_n2", link.bus_addr, 32'h1000);
    start = 1'b1; base_addr = 32'hDEAD_0000; total_words = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t1");
    check("t1 nreq", 32'(nreq - r0), 32'd2);
    check("t1 addr0", req_addr_log[r0], 32'h1000);
    check("t1 addr1", req_addr_log[r0+1], 32'h1020);
    check("t1 len0", 32'(req_len_log[r0]), 32'd7);
    check("t1 len1", 32'(req_len_log[r0+1]), 32'd7);
    check("t1 beats", 32'(nbeats - b0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1 data%0d", i), beat_data[b0+i], 32'(i));
      lmask[i] = beat_last[b0+i];
    end
    check("t1 wlast", 32'(lmask), 32'h8080);
    check("t1 pops", 32'(pops - p0), 32'd16);
    check("t1 done", 32'(ndone - d0), 32'd1);
    repeat (3) @(negedge clk);
    check("t1 no_restart", 32'(busy), 32'd0);

    // short job with words trickling in every 4 cycles
    b0 = nbeats; r0 = nreq; d0 = ndone; p0 = pops; g0 = gaps;
    do_start(32'h2000, 16'd3);
    push_en = 1'b1; push_data = 32'hCAFE_0000;
    @(negedge clk); push_en = 1'b0;
    repeat (3) @(negedge clk);
    push_en = 1'b1; push_data = 32'hCAFE_0001;
    @(negedge clk); push_en = 1'b0;
    repeat (3) @(negedge clk);
    push_en = 1'b1; push_data = 32'hCAFE_0002;
    @(negedge clk); push_en = 1'b0;
    wait_idle("t2");
    check("t2 nreq", 32'(nreq - r0), 32'd1);
    check("t2 addr", req_addr_log[r0], 32'h2000);
    check("t2 len", 32'(req_len_log[r0]), 32'd2);
    check("t2 beats", 32'(nbeats - b0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2 data%0d", i), beat_data[b0+i], 32'hCAFE_0000 + 32'(i));
      lmask[i] = beat_last[b0+i];
    end
    check("t2 wlast", 32'(lmask[2:0]), 32'b100);
    check("t2 pops", 32'(pops - p0), 32'd3);
    check("t2 gaps", 32'(gaps - g0), 32'd4);
    check("t2 done", 32'(ndone - d0), 32'd1);

    // zero-length job
    d0 = ndone; q0 = nreqcyc;
    do_start(32'h3000, 16'd0);
    check("t3 busy_n1", 32'(busy), 32'd1);
    check("t3 done_n1", 32'(done), 32'd0);
    @(negedge clk);
    check("t3 done_n2", 32'(done), 32'd1);
    @(negedge clk);
    check("t3 done_n3", 32'(done), 32'd0);
    check("t3 busy_n3", 32'(busy), 32'd0);
    check("t3 no_req", 32'(nreqcyc - q0), 32'd0);
    check("t3 ndone", 32'(ndone - d0), 32'd1);

    // wready alternating through one full burst
    push_burst(32'h40, 8);
    b0 = nbeats; p0 = pops; c0 = bad_pop;
    wready = 1'b0;
    do_start(32'h4000, 16'd8);
    wready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wready = ~wready;
    end
    wready = 1'b1;
    wait_idle("t4");
    check("t4 beats", 32'(nbeats - b0), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t4 data%0d", i), beat_data[b0+i], 32'h40 + 32'(i));
    check("t4 pops", 32'(pops - p0), 32'd8);
    check("t4 pop_stalled", 32'(bad_pop - c0), 32'd0);
`ifdef FIFO_DRAIN_PERF_EN
    check("t4 stall_cycles", 32'(stall_cycles), 32'd7);
`endif

    // address wrap across 2^32
    push_burst(32'h100, 16);
    b0 = nbeats; r0 = nreq;
    do_start(32'hFFFF_FFF0, 16'd16);
    wait_idle("t5");
    check("t5 nreq", 32'(nreq - r0), 32'd2);
    check("t5 addr0", req_addr_log[r0], 32'hFFFF_FFF0);
    check("t5 addr1", req_addr_log[r0+1], 32'h0000_0010);
    check("t5 beats", 32'(nbeats - b0), 32'd16);
    check("t5 data15", beat_data[b0+15], 32'h10F);

    // reset after 3 beats, then a clean job
    push_burst(32'h50, 8);
    b0 = nbeats; d0 = ndone; p0 = pops;
    do_start(32'h5000, 16'd8);
    for (int i = 0; i < 50 && (nbeats - b0) < 3; i++) @(negedge clk);
    check("t6 beats_pre", 32'(nbeats - b0), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6 async");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("t6 no_done", 32'(ndone - d0), 32'd0);
    check("t6 pops", 32'(pops - p0), 32'd3);
    push_burst(32'h58, 3);
    b0 = nbeats; r0 = nreq; d0 = ndone;
    do_start(32'h6000, 16'd8);
    wait_idle("t6");
    check("t6 nreq", 32'(nreq - r0), 32'd1);
    check("t6 addr", req_addr_log[r0], 32'h6000);
    check("t6 beats", 32'(nbeats - b0), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t6 data%0d", i), beat_data[b0+i], 32'h53 + 32'(i));
    check("t6 done", 32'(ndone - d0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
